// File: rtl/risc_sequencer.sv
// Multi-cycle control sequencer for a small RISC core: fetches instructions
// over a request/acknowledge memory port, decodes them and steps the datapath
// through memory, ALU and register-file write phases until a halt.
module risc_sequencer #(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDRSIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  input  logic [WIDTH-1:0]    mem_rdata,
  input  logic                mem_ack,
  input  logic [WIDTH-1:0]    src_operand,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic [4:0]          psr,
  output logic                alu_go,
  output logic                rf_we,
  output logic [3:0]          rf_waddr,
  output logic [WIDTH-1:0]    rf_wdata,
  output logic [WIDTH-1:0]    ir,
  output logic [ADDRSIZE-1:0] pc,
  output logic                halted,
  output logic                illegal
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, MEM, EXEC, WRITE, HALT} state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_BRA = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_STR = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_MUL = 4'h5;
  localparam logic [3:0] OP_CMP = 4'h6;
  localparam logic [3:0] OP_SHF = 4'h7;
  localparam logic [3:0] OP_ROT = 4'h8;
  localparam logic [3:0] OP_HLT = 4'h9;
  localparam logic [3:0] OP_SUB = 4'hA;
  localparam logic [3:0] OP_AND = 4'hB;

  state_t              state_q, state_d;
  logic [ADDRSIZE-1:0] pc_q, pc_d;
  logic [WIDTH-1:0]    ir_q, ir_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                aluFirst_q, aluFirst_d;

  logic [3:0]          opcode;
  logic                srcType;
  logic                dstType;
  logic [3:0]          ccode;
  logic [11:0]         srcField;
  logic [11:0]         dstField;
  logic                branchTaken;
  logic [WIDTH-1:0]    aluHeld;
  state_t              nextState;

  assign opcode   = ir_q[31:28];
  assign srcType  = ir_q[27];
  assign dstType  = ir_q[26];
  assign ccode    = ir_q[27:24];
  assign srcField = ir_q[23:12];
  assign dstField = ir_q[11:0];
  assign ir       = ir_q;
  assign pc       = pc_q;

  // Where an instruction goes once it finishes: keep fetching while run is high.
  assign nextState = run ? FETCH : IDLE;

  // The ALU result is taken live on the first WRITE cycle and then held, so a
  // memory write presents stable data for the whole handshake.
  assign aluHeld = aluFirst_q ? alu_result : data_q;

  // Branch condition: always, one of the five status flags, or never.
  always_comb begin
    branchTaken = 1'b0;
    case (ccode)
      4'd0:    branchTaken = 1'b1;
      4'd1:    branchTaken = psr[0];
      4'd2:    branchTaken = psr[1];
      4'd3:    branchTaken = psr[2];
      4'd4:    branchTaken = psr[3];
      4'd5:    branchTaken = psr[4];
      default: branchTaken = 1'b0;
    endcase
  end

  // Next-state and output decode; every output defaults low so IDLE and HALT
  // never issue requests or write strobes.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    data_d     = data_q;
    aluFirst_d = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    alu_go     = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    halted     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDRSIZE'(1);
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = nextState;
        case (opcode)
          OP_NOP: ;
          OP_BRA: if (branchTaken) pc_d = ADDRSIZE'(dstField);
          OP_LD: begin
            if (srcType) begin
              rf_we    = 1'b1;
              rf_waddr = dstField[3:0];
              rf_wdata = WIDTH'(srcField);
            end else begin
              state_d = MEM;
            end
          end
          OP_STR: state_d = MEM;
          OP_HLT: state_d = HALT;
          OP_ADD, OP_MUL, OP_CMP, OP_SHF, OP_ROT, OP_SUB, OP_AND: state_d = EXEC;
          default: illegal = 1'b1;
        endcase
      end
      MEM: begin
        mem_req = 1'b1;
        if (opcode == OP_LD) begin
          mem_addr = ADDRSIZE'(srcField);
          if (mem_ack) begin
            data_d  = mem_rdata;
            state_d = WRITE;
          end
        end else begin
          mem_we    = 1'b1;
          mem_addr  = ADDRSIZE'(dstField);
          mem_wdata = src_operand;
          if (mem_ack) state_d = nextState;
        end
      end
      EXEC: begin
        alu_go     = 1'b1;
        aluFirst_d = 1'b1;
        state_d    = WRITE;
      end
      WRITE: begin
        if (opcode == OP_LD) begin
          rf_we    = 1'b1;
          rf_waddr = dstField[3:0];
          rf_wdata = data_q;
          state_d  = nextState;
        end else begin
          data_d = aluHeld;
          if (!dstType) begin
            rf_we    = 1'b1;
            rf_waddr = dstField[3:0];
            rf_wdata = aluHeld;
            state_d  = nextState;
          end else begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ADDRSIZE'(dstField);
            mem_wdata = aluHeld;
            if (mem_ack) state_d = nextState;
          end
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, program counter and instruction registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      data_q     <= '0;
      aluFirst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      data_q     <= data_d;
      aluFirst_q <= aluFirst_d;
    end
  end

endmodule

// File: tb/tb_risc_sequencer.sv
// Scoreboard bench for risc_sequencer: a small memory model answers the
// request/ack port, expected write/strobe events are queued by the stimulus
// and a monitor pops and compares them as the sequencer produces them.
module tb_risc_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic        mem_req;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] src_operand;
  logic [31:0] alu_result;
  logic [4:0]  psr;
  logic        alu_go;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] ir;
  logic [11:0] pc;
  logic        halted;
  logic        illegal;

  localparam logic [3:0] EV_RF  = 4'd1;
  localparam logic [3:0] EV_MEM = 4'd2;
  localparam logic [3:0] EV_ALU = 4'd3;
  localparam logic [3:0] EV_ILL = 4'd4;

  typedef struct packed {
    logic [3:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t         expQ[$];
  logic [31:0] mem [0:4095];
  int          vectors = 0;
  int          miscompares = 0;
  int          ackDelay = 2;
  int          ackCnt = 0;

  logic        prevWait = 1'b0;
  logic [11:0] prevAddr = '0;
  logic        prevWe = 1'b0;
  logic [31:0] prevWdata = '0;

  risc_sequencer #(.WIDTH(32), .ADDRSIZE(12)) dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .src_operand(src_operand), .alu_result(alu_result), .psr(psr), .alu_go(alu_go),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ir(ir), .pc(pc), .halted(halted), .illegal(illegal)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void pushEv(input logic [3:0] kind, input logic [31:0] addr, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    expQ.push_back(e);
  endfunction

  task automatic checkEvent(input logic [3:0] kind, input logic [31:0] addr, input logic [31:0] data);
    ev_t e;
    vectors++;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL unexpectedEvent: got kind %0d addr 0x%08h data 0x%08h, expected none", kind, addr, data);
    end else begin
      e = expQ.pop_front();
      if (e.kind !== kind || e.addr !== addr || e.data !== data) begin
        miscompares++;
        $display("[TB] FAIL event: got kind %0d addr 0x%08h data 0x%08h, expected kind %0d addr 0x%08h data 0x%08h",
                 kind, addr, data, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Memory model: acknowledges a request after ackDelay waiting cycles, one-cycle ack.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset || mem_ack) begin
        mem_ack = 1'b0;
        ackCnt  = 0;
      end else if (mem_req) begin
        if (ackCnt >= ackDelay) begin
          mem_ack = 1'b1;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem[mem_addr];
        end else begin
          ackCnt++;
        end
      end else begin
        ackCnt = 0;
      end
    end
  end

  // Monitor: turns strobes and accepted memory writes into events, and checks
  // that a pending memory request keeps its address, direction and data.
  always @(negedge clk) begin
    if (reset) begin
      if (rf_we) checkEvent(EV_RF, {28'd0, rf_waddr}, rf_wdata);
      if (mem_req && mem_we && mem_ack) checkEvent(EV_MEM, {20'd0, mem_addr}, mem_wdata);
      if (alu_go) checkEvent(EV_ALU, '0, '0);
      if (illegal) checkEvent(EV_ILL, '0, '0);
      if (prevWait && mem_req)
        checkOutput("reqStable", {prevWe, 7'd0, prevAddr, 12'd0} ^ prevWdata,
                    {mem_we, 7'd0, mem_addr, 12'd0} ^ mem_wdata);
      prevWait  = mem_req && !mem_ack;
      prevAddr  = mem_addr;
      prevWe    = mem_we;
      prevWdata = mem_wdata;
    end else begin
      prevWait = 1'b0;
    end
  end

  // Hold reset low for a few cycles, then release it with run high.
  task automatic applyStimulus(input int delay);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    ackDelay = delay;
    run      = 1'b1;
    reset    = 1'b1;
  endtask

  task automatic waitHalted(input string name, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'd0, halted}, 32'd1);
  endtask

  task automatic waitAluGo(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!alu_go && n < budget);
    checkOutput("aluGoSeen", {31'd0, alu_go}, 32'd1);
  endtask

  initial begin
    reset       = 1'b0;
    run         = 1'b0;
    psr         = 5'b01000;
    src_operand = 32'h5555_AAAA;
    alu_result  = 32'h0000_1234;
    for (int i = 0; i < 4096; i++) mem[i] = '0;

    // Reset state
    #12;
    checkOutput("resetPc", {20'd0, pc}, 32'd0);
    checkOutput("resetIr", ir, 32'd0);
    checkOutput("resetOuts", {26'd0, mem_req, mem_we, rf_we, alu_go, halted, illegal}, 32'd0);

    // Program 1: every instruction class, ending in HLT
    mem[12'h000] = 32'h2800_5003;  // LD r3 <- #5
    mem[12'h001] = 32'h1400_0020;  // BRA ZERO -> 0x020 (taken)
    mem[12'h020] = 32'h4400_0100;  // ADD -> MEM[0x100]
    mem[12'h021] = 32'h1100_0040;  // BRA CARRY (not taken)
    mem[12'h022] = 32'h2020_0007;  // LD r7 <- MEM[0x200]
    mem[12'h023] = 32'h3000_0300;  // STR MEM[0x300] <- src
    mem[12'h024] = 32'hB000_0005;  // AND -> r5
    mem[12'h025] = 32'hF000_0000;  // illegal
    mem[12'h026] = 32'h0000_0000;  // NOP
    mem[12'h027] = 32'h9000_0000;  // HLT
    mem[12'h200] = 32'hDEAD_BEEF;
    pushEv(EV_RF, 32'd3, 32'h0000_0005);
    pushEv(EV_ALU, '0, '0);
    pushEv(EV_MEM, 32'h100, 32'h0000_1234);
    pushEv(EV_RF, 32'd7, 32'hDEAD_BEEF);
    pushEv(EV_MEM, 32'h300, 32'h5555_AAAA);
    pushEv(EV_ALU, '0, '0);
    pushEv(EV_RF, 32'd5, 32'h0000_1234);
    pushEv(EV_ILL, '0, '0);
    applyStimulus(2);
    waitHalted("halt1", 2000);
    checkOutput("haltPc", {20'd0, pc}, 32'h028);
    checkOutput("queue1Drained", expQ.size(), 32'd0);
    checkOutput("memModel100", mem[12'h100], 32'h0000_1234);
    for (int i = 0; i < 6; i++) begin
      run = i[0];
      repeat (2) @(negedge clk);
      checkOutput("haltHold", {27'd0, halted, mem_req, rf_we, alu_go, illegal}, 32'h10);
    end
    checkOutput("haltPcHold", {20'd0, pc}, 32'h028);

    // Program 2: untaken branch with psr=0, reset during a fetch wait, pc wrap
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("reset2Pc", {20'd0, pc}, 32'd0);
    checkOutput("reset2Halted", {31'd0, halted}, 32'd0);
    psr          = 5'b00000;
    mem[12'h000] = 32'h1400_0020;  // BRA ZERO, not taken
    mem[12'h001] = 32'h2800_1002;  // LD r2 <- #1
    mem[12'h002] = 32'h1000_0FFF;  // BRA always -> 0xFFF
    mem[12'hFFF] = 32'h9000_0000;  // HLT, pc wraps to 0
    @(negedge clk);
    ackDelay = 6;
    run      = 1'b1;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("fetchWaitReq", {19'd0, mem_req, mem_addr}, 32'h1000);
    #2 reset = 1'b0;
    #1;
    checkOutput("resetDropsReq", {31'd0, mem_req}, 32'd0);
    checkOutput("resetIr", ir, 32'd0);
    pushEv(EV_RF, 32'd2, 32'h0000_0001);
    repeat (2) @(negedge clk);
    ackDelay = 1;
    reset    = 1'b1;
    waitHalted("halt2", 2000);
    checkOutput("wrapPc", {20'd0, pc}, 32'd0);
    checkOutput("wrapIr", ir, 32'h9000_0000);
    checkOutput("queue2Drained", expQ.size(), 32'd0);

    // Program 3: run drops during an ALU op, the op still completes
    alu_result   = 32'h0BAD_F00D;
    mem[12'h000] = 32'h4000_0009;  // ADD -> r9
    mem[12'h001] = 32'h9000_0000;  // HLT
    pushEv(EV_ALU, '0, '0);
    pushEv(EV_RF, 32'd9, 32'h0BAD_F00D);
    applyStimulus(1);
    waitAluGo(200);
    run = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("idlePc", {20'd0, pc}, 32'd1);
    checkOutput("idleQuiet", {29'd0, mem_req, halted, rf_we}, 32'd0);
    checkOutput("queue3Drained", expQ.size(), 32'd0);
    run = 1'b1;
    waitHalted("halt3", 500);
    checkOutput("halt3Pc", {20'd0, pc}, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
